mdl_sprimdet: RTL
=================

Name: mdl_sprimdet

Overview:
- Bench-model link-layer receive stage. Sits directly downstream of the bit-level 8B/10B aligner and consumes its 32b word stream (valid, keyword flag, data).
- Classifies each word as data or a known SATA primitive, and expands CONTp runs back into repeated primitives.
- Drops ALIGNp words and tracks ALIGN lock, so the link-layer models see a clean primitive/data stream.

Parameters:
- LOCK_COUNT, 4: consecutive ALIGNp words (ignoring non-valid cycles) required to assert o_align_lock.
- LOSS_WORDS, 1024: valid words received with no ALIGNp before o_align_lock drops. Width is clog2(LOSS_WORDS+1).
- OPT_PASS_ALIGN, 1'b0: when 1, ALIGNp is also emitted on the output (code 1). When 0, it is consumed silently.

Ports:
- i_clk  input  1  bit-rate model clock, same as the aligner
- i_reset  input  1  synchronous, active-high reset
- i_valid  input  1  one-cycle strobe per received 32b word
- i_keyword  input  1  word held a K character (control word)
- i_data  input  32  received word; byte 0 in [7:0]
- o_valid  output  1  one-cycle strobe per emitted word
- o_prim  output  1  emitted word is a primitive
- o_code  output  4  primitive code; 0 when !o_prim
- o_data  output  32  emitted word; the repeated primitive value during CONT expansion
- o_align_lock  output  1  ALIGN lock status
- o_err  output  1  one-cycle error strobe

Behaviour:
- Reset: all outputs 0. Internal state IDLE, last-primitive register and both counters cleared. A reset mid-CONT run discards the run.
- Latency: exactly 1 cycle from i_valid to o_valid. No backpressure. o_valid only follows i_valid. Outputs hold their value between strobes; o_err is the exception and lasts one cycle.
- Primitive table (i_keyword=1, exact 32b match):
  - 1 ALIGN 7B4A4ABC
  - 2 SYNC B5B5957C
  - 3 CONT 9999AA7C
  - 4 X_RDY 5757B57C
  - 5 R_RDY 4A4A957C
  - 6 SOF 3737B57C
  - 7 EOF D5D5B57C
  - 8 HOLD D5D5AA7C
  - 9 HOLDA 9595AA7C
  - 10 R_IP 5555B57C
  - 11 R_OK 3535B57C
  - 12 R_ERR 5656B57C
  - 13 WTRM 5858B57C
  - 15 UNKNOWN: keyword with no match
- Keyword word with no match: emitted with o_prim=1, code 15, o_err=1. Clears last-primitive to none.
- Non-keyword word in IDLE: emitted with o_prim=0, code 0, o_data=i_data.
- State machine:
  - IDLE -> CONT on a CONT word when last-primitive is a valid code in 2, 4..13. The CONT word itself is not emitted.
  - IDLE, CONT word with last-primitive none, ALIGN or UNKNOWN: o_err=1, nothing emitted, stay IDLE.
  - CONT, non-keyword word: discarded; emits last-primitive again (o_prim=1, its code and 32b value).
  - CONT, ALIGN: handled per ALIGN rules; stay CONT; last-primitive unchanged.
  - CONT, another CONT: no output, no error, stay CONT.
  - CONT, any other keyword word: processed as in IDLE; -> IDLE.
- last-primitive register: updated by every emitted primitive with code 2, 4..13.
- ALIGN handling:
  - Never updates last-primitive.
  - Emitted only if OPT_PASS_ALIGN.
  - Increments the align-run counter, which saturates at LOCK_COUNT. Any other valid word clears the run counter.
  - Reaching LOCK_COUNT sets o_align_lock; lock is set on the cycle the output for the LOCK_COUNT-th ALIGN would appear.
- Loss counter:
  - Cleared by each ALIGN. Otherwise incremented per valid word, saturating.
  - When it reaches LOSS_WORDS while locked: o_align_lock=0 and o_err=1 for one cycle.
- Simultaneous events: lock loss and a bad-CONT or UNKNOWN error in the same cycle give a single o_err pulse.
- No i_valid: no state change at all.

Test Plan:
- Reset, then 4 ALIGN words (7B4A4ABC, keyword=1) spaced 40 cycles apart -> no o_valid; o_align_lock=1 one cycle after the 4th i_valid.
- SYNC, then CONT, then 3 data words (i_keyword=0, 12345678 etc.) -> o_valid 4 times: B5B5957C with code 2, then three more B5B5957C with code 2, o_prim=1. No output for the CONT word.
- After the CONT run, X_RDY arrives -> code 4, state IDLE. Next data word DEADBEEF arrives -> o_prim=0, o_data=DEADBEEF.
- CONT straight after reset, and CONT after data -> o_err pulse each time, no o_valid. Keyword word 11223344 -> code 15, o_err=1.
- Lock achieved, then LOSS_WORDS=1024 data words with no ALIGN -> o_align_lock falls and o_err pulses on the 1024th word's output cycle. An ALIGN inserted at word 1023 prevents the loss.
- i_reset asserted mid-CONT run with OPT_PASS_ALIGN=1 -> all outputs 0 next cycle. A following data word is emitted as data, not as a repeated primitive. A following ALIGN is emitted with code 1.

Source files
------------

// File: rtl/mdl_sprimdet.sv
// mdl_sprimdet: link-layer receive stage for the SATA bench model.
// Classifies aligner words, expands CONTp runs, drops ALIGNp, tracks lock.
//
// Ports:
//   i_clk        bit-rate model clock, shared with the aligner
//   i_reset      synchronous, active-high reset
//   i_valid      one-cycle strobe per received 32b word
//   i_keyword    received word held a K character
//   i_data       received word, byte 0 in [7:0]
//   o_valid      one-cycle strobe per emitted word (1 cycle after i_valid)
//   o_prim       emitted word is a primitive
//   o_code       primitive code, 0 for data, 15 for unknown keyword
//   o_data       emitted word, or repeated primitive during CONT expansion
//   o_align_lock ALIGN lock status
//   o_err        one-cycle error strobe (bad CONT, unknown K, lock loss)
module mdl_sprimdet #(
  parameter int LOCK_COUNT     = 4,
  parameter int LOSS_WORDS     = 1024,
  parameter bit OPT_PASS_ALIGN = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic        i_keyword,
  input  logic [31:0] i_data,
  output logic        o_valid,
  output logic        o_prim,
  output logic [3:0]  o_code,
  output logic [31:0] o_data,
  output logic        o_align_lock,
  output logic        o_err
);

  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_WORDS + 1);

  localparam logic [RW-1:0] RUN_MAX  = RW'(LOCK_COUNT);
  localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_WORDS);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONT = 1'b1;

  localparam logic [31:0] P_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] P_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] P_CONT  = 32'h9999AA7C;
  localparam logic [31:0] P_XRDY  = 32'h5757B57C;
  localparam logic [31:0] P_RRDY  = 32'h4A4A957C;
  localparam logic [31:0] P_SOF   = 32'h3737B57C;
  localparam logic [31:0] P_EOF   = 32'hD5D5B57C;
  localparam logic [31:0] P_HOLD  = 32'hD5D5AA7C;
  localparam logic [31:0] P_HOLDA = 32'h9595AA7C;
  localparam logic [31:0] P_RIP   = 32'h5555B57C;
  localparam logic [31:0] P_ROK   = 32'h3535B57C;
  localparam logic [31:0] P_RERR  = 32'h5656B57C;
  localparam logic [31:0] P_WTRM  = 32'h5858B57C;

  localparam logic [3:0] C_NONE  = 4'd0;
  localparam logic [3:0] C_ALIGN = 4'd1;
  localparam logic [3:0] C_SYNC  = 4'd2;
  localparam logic [3:0] C_CONT  = 4'd3;
  localparam logic [3:0] C_XRDY  = 4'd4;
  localparam logic [3:0] C_RRDY  = 4'd5;
  localparam logic [3:0] C_SOF   = 4'd6;
  localparam logic [3:0] C_EOF   = 4'd7;
  localparam logic [3:0] C_HOLD  = 4'd8;
  localparam logic [3:0] C_HOLDA = 4'd9;
  localparam logic [3:0] C_RIP   = 4'd10;
  localparam logic [3:0] C_ROK   = 4'd11;
  localparam logic [3:0] C_RERR  = 4'd12;
  localparam logic [3:0] C_WTRM  = 4'd13;
  localparam logic [3:0] C_UNK   = 4'd15;

  // Only the code of the last primitive is kept; its word is rebuilt
  // from the table when a CONT run needs to repeat it.
  function automatic logic [31:0] prim_word(
    input logic [3:0] c
  );
    logic [31:0] w;
    w = 32'h0;
    case (c)
      C_SYNC:  w = P_SYNC;
      C_XRDY:  w = P_XRDY;
      C_RRDY:  w = P_RRDY;
      C_SOF:   w = P_SOF;
      C_EOF:   w = P_EOF;
      C_HOLD:  w = P_HOLD;
      C_HOLDA: w = P_HOLDA;
      C_RIP:   w = P_RIP;
      C_ROK:   w = P_ROK;
      C_RERR:  w = P_RERR;
      C_WTRM:  w = P_WTRM;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [3:0]    last_code;
  logic [3:0]    last_nxt;
  logic [RW-1:0] run_cnt;
  logic [RW-1:0] run_nxt;
  logic [LW-1:0] loss_cnt;
  logic [LW-1:0] loss_nxt;

  logic [3:0]  in_code;
  logic        is_align;
  logic        is_cont;
  logic        is_unk;
  logic        is_data;
  logic        last_ok;
  logic        lock_set;
  logic        lock_loss;
  logic        bad_cont;
  logic        emit;
  logic        e_prim;
  logic [3:0]  e_code;
  logic [31:0] e_data;

  always_comb begin
    in_code = C_NONE;
    if (i_keyword) begin
      case (i_data)
        P_ALIGN: in_code = C_ALIGN;
        P_SYNC:  in_code = C_SYNC;
        P_CONT:  in_code = C_CONT;
        P_XRDY:  in_code = C_XRDY;
        P_RRDY:  in_code = C_RRDY;
        P_SOF:   in_code = C_SOF;
        P_EOF:   in_code = C_EOF;
        P_HOLD:  in_code = C_HOLD;
        P_HOLDA: in_code = C_HOLDA;
        P_RIP:   in_code = C_RIP;
        P_ROK:   in_code = C_ROK;
        P_RERR:  in_code = C_RERR;
        P_WTRM:  in_code = C_WTRM;
        default: in_code = C_UNK;
      endcase
    end
  end

  assign is_align = (in_code == C_ALIGN);
  assign is_cont  = (in_code == C_CONT);
  assign is_unk   = (in_code == C_UNK);
  assign is_data  = (in_code == C_NONE);

  // last_code only ever holds none or a repeatable primitive.
  assign last_ok = (last_code != C_NONE);

  always_comb begin
    run_nxt  = '0;
    loss_nxt = '0;
    if (is_align) begin
      run_nxt = (run_cnt == RUN_MAX) ? run_cnt
                                     : run_cnt + RW'(1);
    end else begin
      loss_nxt = (loss_cnt == LOSS_MAX) ? loss_cnt
                                        : loss_cnt + LW'(1);
    end
  end

  assign lock_set  = is_align && (run_nxt == RUN_MAX);
  assign lock_loss = o_align_lock && !is_align &&
                     (loss_nxt == LOSS_MAX);

  always_comb begin
    state_nxt = state;
    last_nxt  = last_code;
    bad_cont  = 1'b0;
    emit      = 1'b0;
    e_prim    = 1'b0;
    e_code    = C_NONE;
    e_data    = i_data;
    unique case (1'b1)
      is_align: begin
        if (OPT_PASS_ALIGN) begin
          emit   = 1'b1;
          e_prim = 1'b1;
          e_code = C_ALIGN;
        end
      end
      is_cont: begin
        // A CONT inside a run is absorbed silently.
        if (state == S_IDLE) begin
          if (last_ok) begin
            state_nxt = S_CONT;
          end else begin
            bad_cont = 1'b1;
          end
        end
      end
      is_data: begin
        emit = 1'b1;
        if (state == S_CONT) begin
          e_prim = 1'b1;
          e_code = last_code;
          e_data = prim_word(last_code);
        end
      end
      is_unk: begin
        emit      = 1'b1;
        e_prim    = 1'b1;
        e_code    = C_UNK;
        last_nxt  = C_NONE;
        state_nxt = S_IDLE;
      end
      default: begin
        emit      = 1'b1;
        e_prim    = 1'b1;
        e_code    = in_code;
        last_nxt  = in_code;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= S_IDLE;
      last_code    <= C_NONE;
      run_cnt      <= '0;
      loss_cnt     <= '0;
      o_valid      <= 1'b0;
      o_prim       <= 1'b0;
      o_code       <= C_NONE;
      o_data       <= 32'h0;
      o_align_lock <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      if (i_valid) begin
        state     <= state_nxt;
        last_code <= last_nxt;
        run_cnt   <= run_nxt;
        loss_cnt  <= loss_nxt;
        o_valid   <= emit;
        o_err     <= bad_cont | is_unk | lock_loss;
        if (lock_set) begin
          o_align_lock <= 1'b1;
        end else if (lock_loss) begin
          o_align_lock <= 1'b0;
        end
        if (emit) begin
          o_prim <= e_prim;
          o_code <= e_code;
          o_data <= e_data;
        end
      end
    end
  end

endmodule
